// File: rtl/fifo_leveled.sv
// ----------------------------------------------------------------------------
// fifo_leveled
//   Single-clock FIFO with arbitrary (non power-of-two) depth, occupancy count,
//   programmable almost-full / almost-empty marks, sticky overflow / underflow
//   flags, synchronous flush, and either show-ahead or registered read data.
//   It decouples the host-side write path from the display-command consumer.
//
// Ports
//   clk          clock, every state update on the rising edge
//   rst          asynchronous reset, active high
//   flush        synchronous clear of contents and sticky flags (top priority)
//   write_en     push write_data when there is room (or a same-cycle pop)
//   write_data   word to push
//   read_en      pop the head word when not empty
//   read_data    FWFT=1: current head word; FWFT=0: word popped last cycle
//   read_valid   FWFT=1: !empty; FWFT=0: high the cycle after an accepted pop
//   empty/full   level == 0 / level == DEPTH
//   almost_empty level <= AE_LEVEL
//   almost_full  level >= AF_LEVEL
//   level        current occupancy, 0..DEPTH
//   overflow     sticky: a write was refused because the FIFO was full
//   underflow    sticky: a read was refused because the FIFO was empty
// ----------------------------------------------------------------------------
module fifo_leveled #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       write_en,
    input  logic [WIDTH-1:0]           write_data,
    input  logic                       read_en,
    output logic [WIDTH-1:0]           read_data,
    output logic                       read_valid,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] AF_MARK  = LVL_W'(AF_LEVEL);
    localparam logic [LVL_W-1:0] AE_MARK  = LVL_W'(AE_LEVEL);
    localparam logic             AF_RESET = (AF_LEVEL == 0);

    // Storage and state
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;
    logic             empty_q,  empty_d;
    logic             full_q,   full_d;
    logic             ae_q,     ae_d;
    logic             af_q,     af_d;
    logic             ovf_q,    ovf_d;
    logic             unf_q,    unf_d;

    logic             wr_acc;
    logic             rd_acc;

    // Explicit wrap so non power-of-two depths never index past the array.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Acceptance is decided on registered flags only, so no input reaches a
    // status output combinationally. A pop frees a slot for a same-cycle push
    // when full; a push never feeds a same-cycle pop when empty.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // branch can leave it unassigned and infer a latch.
        rd_acc   = read_en  & ~empty_q & ~flush;
        wr_acc   = write_en & (~full_q | (read_en & ~empty_q)) & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wr_acc) wr_ptr_d = ptr_next(wr_ptr_q);
            if (rd_acc) rd_ptr_d = ptr_next(rd_ptr_q);
            level_d = level_q + LVL_W'(wr_acc) - LVL_W'(rd_acc);
            if (write_en & full_q & ~rd_acc) ovf_d = 1'b1;
            if (read_en & empty_q)           unf_d = 1'b1;
        end

        // Status flags are registered from the next level so they change on
        // the same edge as level itself.
        empty_d = (level_d == '0);
        full_d  = (level_d == LVL_FULL);
        ae_d    = (level_d <= AE_MARK);
        af_d    = (level_d >= AF_MARK);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ae_q     <= 1'b1;
            af_q     <= AF_RESET;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ae_q     <= ae_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // NOTE: the storage array has no reset; pointers and level define which
    // entries are meaningful, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= write_data;
    end

    generate
        if (FWFT != 0) begin : g_show_ahead
            // Head word is visible as soon as it is stored; undefined when empty.
            assign read_data  = mem_q[rd_ptr_q];
            assign read_valid = ~empty_q;
        end else begin : g_registered
            logic [WIDTH-1:0] rdata_q;
            logic             rvalid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_acc;
                    if (rd_acc) rdata_q <= mem_q[rd_ptr_q];
                end
            end

            assign read_data  = rdata_q;
            assign read_valid = rvalid_q;
        end
    endgenerate

    assign level        = level_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = ae_q;
    assign almost_full  = af_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_leveled.sv
// ----------------------------------------------------------------------------
// tb_fifo_leveled
//   Directed bench for fifo_leveled. Three instances:
//     unit 0: DEPTH=16, AF=12, AE=2, show-ahead
//     unit 1: DEPTH=5,  AF=4,  AE=1, show-ahead (non power-of-two wrap)
//     unit 2: DEPTH=4,  AF=3,  AE=1, registered read
//   A per-unit queue holds the words the FIFO should contain; accepted writes
//   push, accepted reads pop and compare against the DUT read data.
// ----------------------------------------------------------------------------
module tb_fifo_leveled;

    localparam int NU = 3;
    localparam int DEP [NU] = '{16, 5, 4};
    localparam int AFL [NU] = '{12, 4, 3};
    localparam int AEL [NU] = '{2, 1, 1};
    localparam int FW  [NU] = '{1, 1, 0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fl [NU];
    logic       we [NU];
    logic       re [NU];
    logic [7:0] wd [NU];
    logic [7:0] rd [NU];
    logic       rv [NU];
    logic       em [NU];
    logic       fu [NU];
    logic       ae [NU];
    logic       af [NU];
    logic       ov [NU];
    logic       uf [NU];
    logic [4:0] lv0;
    logic [2:0] lv1;
    logic [2:0] lv2;

    // Reference model
    logic [7:0] sbq  [NU][$];
    bit         ov_m [NU];
    bit         uf_m [NU];

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    fifo_leveled #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(1)) u_d16 (
        .clk(clk), .rst(rst), .flush(fl[0]), .write_en(we[0]), .write_data(wd[0]),
        .read_en(re[0]), .read_data(rd[0]), .read_valid(rv[0]), .empty(em[0]),
        .full(fu[0]), .almost_empty(ae[0]), .almost_full(af[0]), .level(lv0),
        .overflow(ov[0]), .underflow(uf[0])
    );

    fifo_leveled #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1)) u_d5 (
        .clk(clk), .rst(rst), .flush(fl[1]), .write_en(we[1]), .write_data(wd[1]),
        .read_en(re[1]), .read_data(rd[1]), .read_valid(rv[1]), .empty(em[1]),
        .full(fu[1]), .almost_empty(ae[1]), .almost_full(af[1]), .level(lv1),
        .overflow(ov[1]), .underflow(uf[1])
    );

    fifo_leveled #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) u_reg (
        .clk(clk), .rst(rst), .flush(fl[2]), .write_en(we[2]), .write_data(wd[2]),
        .read_en(re[2]), .read_data(rd[2]), .read_valid(rv[2]), .empty(em[2]),
        .full(fu[2]), .almost_empty(ae[2]), .almost_full(af[2]), .level(lv2),
        .overflow(ov[2]), .underflow(uf[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] lvl_of(input int u);
        case (u)
            0:       return 32'(lv0);
            1:       return 32'(lv1);
            default: return 32'(lv2);
        endcase
    endfunction

    task automatic model_reset();
        for (int u = 0; u < NU; u++) begin
            sbq[u].delete();
            ov_m[u] = 1'b0;
            uf_m[u] = 1'b0;
        end
    endtask

    // Compare every status output of unit u against the model.
    task automatic check_status(input int u, input string tag);
        int n;
        n = sbq[u].size();
        check({tag, ".level"}, lvl_of(u), 32'(n));
        check({tag, ".empty"}, 32'(em[u]), 32'(n == 0));
        check({tag, ".full"},  32'(fu[u]), 32'(n == DEP[u]));
        check({tag, ".aempty"}, 32'(ae[u]), 32'(n <= AEL[u]));
        check({tag, ".afull"}, 32'(af[u]), 32'(n >= AFL[u]));
        check({tag, ".ovf"},   32'(ov[u]), 32'(ov_m[u]));
        check({tag, ".unf"},   32'(uf[u]), 32'(uf_m[u]));
        if (FW[u] != 0) begin
            check({tag, ".rvalid"}, 32'(rv[u]), 32'(n != 0));
            if (n != 0) check({tag, ".head"}, 32'(rd[u]), 32'(sbq[u][0]));
        end
    endtask

    // One clock cycle on unit u; called and returns at a falling edge.
    task automatic cyc(input int u, input logic w, input logic [7:0] d,
                       input logic r, input logic f, input string tag);
        int         n;
        logic       ra;
        logic       wa;
        logic [7:0] exp_d;
        n     = sbq[u].size();
        ra    = r && (n != 0) && !f;
        wa    = w && ((n < DEP[u]) || ra) && !f;
        exp_d = 8'h00;

        if (f) begin
            sbq[u].delete();
            ov_m[u] = 1'b0;
            uf_m[u] = 1'b0;
        end else begin
            if (w && (n == DEP[u]) && !ra) ov_m[u] = 1'b1;
            if (r && (n == 0))             uf_m[u] = 1'b1;
            if (ra) begin
                exp_d = sbq[u].pop_front();
                if (FW[u] != 0) check({tag, ".pop"}, 32'(rd[u]), 32'(exp_d));
            end
            if (wa) sbq[u].push_back(d);
        end

        fl[u] = f;
        we[u] = w;
        wd[u] = d;
        re[u] = r;
        @(posedge clk);
        @(negedge clk);
        fl[u] = 1'b0;
        we[u] = 1'b0;
        re[u] = 1'b0;

        if (FW[u] == 0) begin
            check({tag, ".rvalid"}, 32'(rv[u]), 32'(ra));
            if (ra) check({tag, ".pop"}, 32'(rd[u]), 32'(exp_d));
        end
        check_status(u, tag);
    endtask

    initial begin
        for (int u = 0; u < NU; u++) begin
            fl[u] = 1'b0;
            we[u] = 1'b0;
            re[u] = 1'b0;
            wd[u] = 8'h00;
        end
        model_reset();

        // Reset state
        @(negedge clk);
        for (int u = 0; u < NU; u++) check_status(u, "reset");
        check("reset.rvalid_reg", 32'(rv[2]), 32'd0);
        check("reset.rdata_reg",  32'(rd[2]), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Fill to full, then drain in order
        for (int i = 1; i <= 16; i++) cyc(0, 1'b1, 8'(i), 1'b0, 1'b0, "fill");
        for (int i = 0; i < 16; i++)  cyc(0, 1'b0, 8'h00, 1'b1, 1'b0, "drain");

        // Overflow when full, then simultaneous read+write at full
        for (int i = 1; i <= 16; i++) cyc(0, 1'b1, 8'(i), 1'b0, 1'b0, "refill");
        cyc(0, 1'b1, 8'hAA, 1'b0, 1'b0, "ovf_wr");
        cyc(0, 1'b1, 8'hBB, 1'b1, 1'b0, "full_rw");
        for (int i = 0; i < 16; i++)  cyc(0, 1'b0, 8'h00, 1'b1, 1'b0, "drain2");

        // Underflow, then read+write while empty
        cyc(0, 1'b0, 8'h00, 1'b1, 1'b0, "unf_rd");
        cyc(0, 1'b1, 8'h55, 1'b1, 1'b0, "empty_rw");

        // Show-ahead: new head visible before read_en
        cyc(0, 1'b0, 8'h00, 1'b1, 1'b0, "pop55");
        cyc(0, 1'b1, 8'h3C, 1'b0, 1'b0, "fwft_wr");
        check("fwft.head_early", 32'(rd[0]), 32'h3C);
        cyc(0, 1'b0, 8'h00, 1'b1, 1'b0, "fwft_rd");

        // Depth 5: staggered write/read pairs through pointer wrap, then overflow
        for (int k = 0; k < 14; k++)
            cyc(1, k < 12, 8'(8'h80 + k), k >= 2, 1'b0, "d5_stream");
        for (int k = 0; k < 6; k++) cyc(1, 1'b1, 8'(8'hC0 + k), 1'b0, 1'b0, "d5_fill");
        for (int k = 0; k < 5; k++) cyc(1, 1'b0, 8'h00, 1'b1, 1'b0, "d5_drain");

        // Registered read: data and valid exactly one cycle after accept
        cyc(2, 1'b1, 8'h3C, 1'b0, 1'b0, "reg_wr");
        check("reg.no_valid_yet", 32'(rv[2]), 32'd0);
        cyc(2, 1'b0, 8'h00, 1'b1, 1'b0, "reg_rd");
        cyc(2, 1'b0, 8'h00, 1'b0, 1'b0, "reg_idle");
        check("reg.rdata_hold", 32'(rd[2]), 32'h3C);
        for (int k = 0; k < 5; k++) cyc(2, 1'b1, 8'(8'hA1 + k), 1'b0, 1'b0, "reg_fill");
        for (int k = 0; k < 5; k++) cyc(2, 1'b0, 8'h00, 1'b1, 1'b0, "reg_drain");

        // Flush with write_en at level 7 with overflow still set
        for (int i = 0; i < 7; i++) cyc(0, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0, "pre_flush");
        check("pre_flush.ovf", 32'(ov[0]), 32'd1);
        cyc(0, 1'b1, 8'hEE, 1'b0, 1'b1, "flush");
        cyc(0, 1'b1, 8'h77, 1'b0, 1'b0, "post_flush");

        // Asynchronous reset in the middle of a write burst
        for (int i = 0; i < 3; i++) cyc(0, 1'b1, 8'(8'h90 + i), 1'b0, 1'b0, "burst");
        we[0] = 1'b1;
        wd[0] = 8'h99;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        for (int u = 0; u < NU; u++) check_status(u, "mid_rst");
        check("mid_rst.rdata_reg",  32'(rd[2]), 32'd0);
        check("mid_rst.rvalid_reg", 32'(rv[2]), 32'd0);
        @(negedge clk);
        we[0] = 1'b0;
        rst   = 1'b0;
        check_status(0, "rst_held");
        @(negedge clk);
        check_status(0, "after_rst");
        cyc(0, 1'b1, 8'h42, 1'b0, 1'b0, "after_rst_wr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
